// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with load, change pulse and saturating toggle counter.
// Optional registered parity of q is enabled by defining JK_REG_BANK_PARITY_EN.
module jk_reg_bank #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             changed,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             parity
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_cycle;

  // Characteristic equation: set on J, keep unless K, so J&K toggles.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (j & ~q_q) | (~k & q_q);
    end
  end

  assign changed_d = (q_d != q_q);
  assign tog_cycle = en & ~load & (|(j & k));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (tog_cycle && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef JK_REG_BANK_PARITY_EN
  logic parity_q;

  // Registered from q_d so it tracks q with no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= ^RST_VAL;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign changed = changed_q;
  assign tog_cnt = cnt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Randomised and directed bench for jk_reg_bank against a per-bit behavioural model.
module tb_jk_reg_bank;

  localparam int           W   = 4;
  localparam int           CW  = 4;
  localparam logic [W-1:0] RV  = '0;
  localparam int           MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, load, clr_cnt;
  logic [W-1:0]  d, j, k;
  logic [W-1:0]  q, q_bar;
  logic          changed, parity;
  logic [CW-1:0] tog_cnt;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(W), .RST_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .clr_cnt(clr_cnt), .q(q), .q_bar(q_bar), .changed(changed),
    .tog_cnt(tog_cnt), .parity(parity)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state
  logic [W-1:0] mq;
  bit           mchg;
  int           mcnt;

  task automatic model_edge();
    logic [W-1:0] nq;
    bit tog;
    if (rst) begin
      mq = RV; mchg = 0; mcnt = 0;
    end else begin
      nq  = mq;
      tog = 0;
      if (load) nq = d;
      else if (en) begin
        for (int i = 0; i < W; i++) begin
          case ({j[i], k[i]})
            2'b01:   nq[i] = 1'b0;
            2'b10:   nq[i] = 1'b1;
            2'b11: begin nq[i] = ~mq[i]; tog = 1; end
            default: nq[i] = mq[i];
          endcase
        end
      end
      mchg = (nq != mq);
      if (clr_cnt)  mcnt = 0;
      else if (tog) mcnt = (mcnt + 1 > MAXC) ? MAXC : mcnt + 1;
      mq = nq;
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic c,
                       input logic [W-1:0] dd, input logic [W-1:0] jj, input logic [W-1:0] kk);
    rst = r; load = l; en = e; clr_cnt = c; d = dd; j = jj; k = kk;
  endtask

  task automatic step();
    logic [W-1:0] nb;
    logic         ep;
    @(posedge clk);
    model_edge();
    #1;
    nb = ~mq;
`ifdef JK_REG_BANK_PARITY_EN
    ep = ^mq;
`else
    ep = 1'b0;
`endif
    check("q", q, mq);
    check("q_bar", q_bar, nb);
    check("changed", changed, mchg);
    check("tog_cnt", tog_cnt, mcnt);
    check("parity", parity, ep);
  endtask

  initial begin
    mq = RV; mchg = 0; mcnt = 0;
    drive(1, 0, 0, 0, '0, '0, '0);
    step(); step();
    check("rst_q", q, 4'b0000);
    check("rst_qbar", q_bar, 4'b1111);

    drive(0, 0, 1, 0, '0, 4'b1010, 4'b0101);
    step();
    check("set_clr_q", q, 4'b1010);
    check("set_clr_chg", changed, 1'b1);
    drive(0, 0, 1, 0, '0, 4'b0000, 4'b0000);
    step();
    check("hold_chg", changed, 1'b0);

    drive(0, 0, 1, 0, '0, 4'b1111, 4'b1111);
    step();
    check("tog1_q", q, 4'b0101);
    step();
    check("tog2_q", q, 4'b1010);
    check("tog2_cnt", tog_cnt, 4'd2);

    drive(0, 1, 0, 0, 4'b0011, 4'b1111, 4'b1111);
    step();
    check("load_q", q, 4'b0011);
    check("load_cnt", tog_cnt, 4'd2);
    step();
    check("reload_chg", changed, 1'b0);

    drive(0, 0, 1, 0, '0, 4'b1111, 4'b1111);
    repeat (20) step();
    check("sat_cnt", tog_cnt, 4'd15);
    drive(0, 0, 1, 1, '0, 4'b1111, 4'b1111);
    step();
    check("clr_cnt", tog_cnt, 4'd0);
    check("clr_tog_q", q, 4'b1100);

    drive(1, 1, 1, 0, 4'b1111, 4'b1111, 4'b1111);
    step();
    check("rst_load_q", q, 4'b0000);
    drive(0, 1, 0, 0, 4'b0111, '0, '0);
    step();
    drive(0, 1, 0, 0, 4'b0110, '0, '0);
    step();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(5) == 0), ($urandom_range(3) != 0),
            ($urandom_range(9) == 0), W'($urandom), W'($urandom), W'($urandom));
      step();
    end

    // Long toggle train with an occasional reset to exercise mid-train recovery
    for (int n = 0; n < 60; n++) begin
      drive((n == 30), 1'b0, 1'b1, 1'b0, '0, W'($urandom) | 4'b0001, 4'b0001);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
